uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 51: clock cycles per bit period; legal range 8..1023.
REQ-002 clk  input  1  single system clock; all flops rising-edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 rx  input  1  UART serial line, idle high, asynchronous to clk.
REQ-005 rx_data  output  8  received byte, LSB first on line.
REQ-006 rx_valid  output  1  rx_data holds an unconsumed byte.
REQ-007 rx_ready  input  1  consumer accepts the byte when rx_valid && rx_ready.
REQ-008 frame_err  output  1  sticky; stop bit sampled low.
REQ-009 overrun_err  output  1  sticky; byte completed while rx_valid still high.
REQ-010 parity_err  output  1  sticky; parity mismatch (see Configuration).
REQ-011 err_clr  input  1  one-cycle pulse clears all sticky error flags.

Function
REQ-012 rx SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value rxs.
REQ-013 States SHALL be IDLE, START, DATA, PARITY, STOP; PARITY is reachable only with the macro defined.
REQ-014 IDLE: a 1-to-0 transition on rxs SHALL load the bit counter with CLKS_PER_BIT/2 (integer division) and enter START.
REQ-015 START: at the half-bit point, rxs==0 SHALL enter DATA and reload the counter with CLKS_PER_BIT; rxs==1 is a glitch and SHALL return to IDLE with no flag.
REQ-016 DATA: the line SHALL be sampled once per CLKS_PER_BIT cycles. Each sample shifts into the shift register MSB, with right shift. After the 8th sample the FSM SHALL enter PARITY (macro defined) or STOP.
REQ-017 STOP: at the stop sample the FSM SHALL return to IDLE regardless of the sampled value. rxs==0 SHALL set frame_err and the byte SHALL be discarded (rx_valid unchanged).
REQ-018 On a good stop bit, the following cycle SHALL load rx_data from the shift register and set rx_valid.
REQ-019 If rx_valid is already high at that point, overrun_err SHALL set, rx_data SHALL be overwritten with the new byte, and rx_valid SHALL stay high.
REQ-020 rx_valid SHALL clear the cycle after rx_valid && rx_ready. If a new byte loads in the same cycle as the handshake, the load SHALL win: rx_valid stays 1 and no overrun is flagged.
REQ-021 rx_data SHALL remain stable while rx_valid is high, except on overrun.
REQ-022 When a flag set and err_clr coincide, the set SHALL win.
REQ-023 After STOP, IDLE SHALL accept a new falling edge immediately. Back-to-back frames with a single stop bit SHALL be received without loss.
REQ-024 The bit counter SHALL be 10 bits wide and count down to 1. A sample is taken when the counter is 1, and the counter then reloads.

Reset
REQ-025 While rst_n is low: state=IDLE, rx_data=0, rx_valid=0, frame_err=0, overrun_err=0, parity_err=0, counters=0, synchronizer flops=1.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no output or flag. After release, reception SHALL resume only on the next falling edge.

Configuration
REQ-027 Macro UART_RX_PARITY_EN:
- Defined: one even-parity bit follows the data bits and is sampled in PARITY. If the XOR of the 8 data bits and the parity bit is 1, parity_err SHALL set and the byte SHALL be discarded; the STOP state is still executed.
- Not defined: frames carry no parity bit, and parity_err SHALL be tied 0.

Verification (CLKS_PER_BIT=51)
REQ-028 Frame 0xA5, 8N1, rx_ready=0 -> rx_data=0xA5 and rx_valid=1 about 9.5 bit periods plus 3 cycles after the start edge; no flags set.
REQ-029 rx low for 20 cycles then high -> state returns to IDLE, rx_valid stays 0, no flags set.
REQ-030 Frame 0x3C with the stop bit held low -> frame_err=1, rx_valid=0. Pulse err_clr -> frame_err=0.
REQ-031 Frames 0x11 then 0x22 back-to-back with rx_ready=0 -> rx_data=0x22, rx_valid=1, overrun_err=1.
REQ-032 rx_ready held 1 over 0x55, 0xAA, 0xFF back-to-back -> three one-cycle rx_valid pulses carrying those values in order.
REQ-033 Reset pulsed mid DATA of 0x81, then a clean 0x7E -> only 0x7E is delivered. With UART_RX_PARITY_EN and 0x07 sent with parity 0 -> parity_err=1 and no rx_valid.

Source files
------------

// File: rtl/uart_rx_if.sv
// Byte-delivery handshake between uart_rx (master) and its consumer (slave).
interface uart_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_valid, input  rx_ready);
  modport slave  (input  rx_data, input  rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx.sv
// 8-bit UART receiver, 1 start / 8 data (LSB first) / 1 stop, with sticky error flags.
// Define UART_RX_PARITY_EN to expect one even-parity bit between data and stop.
module uart_rx #(
  parameter int CLKS_PER_BIT = 51
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  input  logic err_clr,
  output logic frame_err,
  output logic overrun_err,
  output logic parity_err,
  uart_rx_if.master rx_if
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  localparam logic [9:0] HALF_BIT = 10'(CLKS_PER_BIT / 2);
  localparam logic [9:0] FULL_BIT = 10'(CLKS_PER_BIT);

  logic       rx_meta_q, rxs_q, rxs_prev_q;
  state_e     state_q, state_d;
  logic [9:0] cnt_q, cnt_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       load_q, load_d;
  logic       rx_valid_q, rx_valid_d;
  logic       frame_err_q, frame_err_d;
  logic       overrun_err_q, overrun_err_d;
  logic       frame_set, overrun_set;
  logic       tick;

`ifdef UART_RX_PARITY_EN
  logic par_bad_q, par_bad_d;
  logic parity_err_q, parity_err_d;
  logic par_set;
`endif

  // Counter expiry marks the mid-bit sampling point.
  assign tick = (cnt_q == 10'd1);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    load_d      = 1'b0;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_set   = 1'b0;
    overrun_set = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d   = par_bad_q;
    par_set     = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (rxs_prev_q && !rxs_q) begin
          cnt_d   = HALF_BIT;
          state_d = START;
        end
      end
      START: begin
        if (!tick) begin
          cnt_d = cnt_q - 10'd1;
        end else if (!rxs_q) begin
          cnt_d     = FULL_BIT;
          bit_idx_d = 3'd0;
          state_d   = DATA;
        end else begin
          state_d = IDLE;
        end
      end
      DATA: begin
        if (!tick) begin
          cnt_d = cnt_q - 10'd1;
        end else begin
          shift_d   = {rxs_q, shift_q[7:1]};
          cnt_d     = FULL_BIT;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (!tick) begin
          cnt_d = cnt_q - 10'd1;
        end else begin
          par_bad_d = ^{shift_q, rxs_q};
          par_set   = par_bad_d;
          cnt_d     = FULL_BIT;
          state_d   = STOP;
        end
      end
`endif
      STOP: begin
        if (!tick) begin
          cnt_d = cnt_q - 10'd1;
        end else begin
          state_d = IDLE;
          if (!rxs_q) begin
            frame_set = 1'b1;
          end else begin
`ifdef UART_RX_PARITY_EN
            load_d = !par_bad_q;
`else
            load_d = 1'b1;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A load in the same cycle as a handshake wins and is not an overrun.
    if (load_q) begin
      rx_data_d   = shift_q;
      rx_valid_d  = 1'b1;
      overrun_set = rx_valid_q && !rx_if.rx_ready;
    end else if (rx_valid_q && rx_if.rx_ready) begin
      rx_valid_d = 1'b0;
    end

    frame_err_d   = frame_set   | (frame_err_q   & ~err_clr);
    overrun_err_d = overrun_set | (overrun_err_q & ~err_clr);
`ifdef UART_RX_PARITY_EN
    parity_err_d  = par_set     | (parity_err_q  & ~err_clr);
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q     <= 1'b1;
      rxs_q         <= 1'b1;
      rxs_prev_q    <= 1'b1;
      state_q       <= IDLE;
      cnt_q         <= '0;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      load_q        <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q     <= 1'b0;
      parity_err_q  <= 1'b0;
`endif
    end else begin
      rx_meta_q     <= rx;
      rxs_q         <= rx_meta_q;
      rxs_prev_q    <= rxs_q;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_idx_q     <= bit_idx_d;
      shift_q       <= shift_d;
      load_q        <= load_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      frame_err_q   <= frame_err_d;
      overrun_err_q <= overrun_err_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q     <= par_bad_d;
      parity_err_q  <= parity_err_d;
`endif
    end
  end

  assign rx_if.rx_data  = rx_data_q;
  assign rx_if.rx_valid = rx_valid_q;
  assign frame_err      = frame_err_q;
  assign overrun_err    = overrun_err_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err     = parity_err_q;
`else
  assign parity_err     = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at CLKS_PER_BIT=51; parity case runs when UART_RX_PARITY_EN is defined.
module tb_uart_rx;
  localparam int CPB = 51;

  logic clk, rst_n, rx, err_clr;
  logic frame_err, overrun_err, parity_err;
  uart_rx_if ifc ();

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx          (rx),
    .err_clr     (err_clr),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .parity_err  (parity_err),
    .rx_if       (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int rise_cyc = 0;
  logic valid_prev = 1'b0;
  logic [7:0] got[$];

  // Cycle counter, rx_valid rise timestamp and handshake capture.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (ifc.rx_valid && !valid_prev) rise_cyc = cyc;
    valid_prev = ifc.rx_valid;
    if (ifc.rx_valid && ifc.rx_ready) got.push_back(ifc.rx_data);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic bit_wait();
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    rx = 1'b0;
    bit_wait();
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      bit_wait();
    end
`ifdef UART_RX_PARITY_EN
    rx = ^d;
    bit_wait();
`endif
    rx = stop_bit;
    bit_wait();
    rx = 1'b1;
  endtask

  initial begin
    int start_cyc;
    int lat;
    logic [7:0] b81;
    rst_n = 1'b0;
    rx = 1'b1;
    err_clr = 1'b0;
    ifc.rx_ready = 1'b0;
    repeat (5) @(negedge clk);
    check("reset_rx_data", ifc.rx_data, 8'h00);
    check("reset_rx_valid", ifc.rx_valid, 1'b0);
    check("reset_frame_err", frame_err, 1'b0);
    check("reset_overrun_err", overrun_err, 1'b0);
    check("reset_parity_err", parity_err, 1'b0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Single 0xA5 frame, not consumed.
    rise_cyc = 0;
    start_cyc = cyc;
    send_frame(8'hA5, 1'b1);
    repeat (5) @(negedge clk);
    lat = rise_cyc - start_cyc;
    check("a5_data", ifc.rx_data, 8'hA5);
    check("a5_valid", ifc.rx_valid, 1'b1);
    check("a5_latency_window", (lat >= 484 && lat <= 492), 1'b1);
    check("a5_frame_err", frame_err, 1'b0);
    check("a5_overrun_err", overrun_err, 1'b0);
    check("a5_parity_err", parity_err, 1'b0);
    repeat (100) @(negedge clk);
    check("a5_data_held", ifc.rx_data, 8'hA5);
    check("a5_valid_held", ifc.rx_valid, 1'b1);
    ifc.rx_ready = 1'b1;
    @(negedge clk);
    ifc.rx_ready = 1'b0;
    @(negedge clk);
    check("a5_consumed", ifc.rx_valid, 1'b0);

    // Start-bit glitch of 20 cycles.
    rx = 1'b0;
    repeat (20) @(negedge clk);
    rx = 1'b1;
    repeat (60) @(negedge clk);
    check("glitch_valid", ifc.rx_valid, 1'b0);
    check("glitch_frame_err", frame_err, 1'b0);
    check("glitch_overrun_err", overrun_err, 1'b0);

    // Framing error with stop bit low, then clear.
    send_frame(8'h3C, 1'b0);
    repeat (5) @(negedge clk);
    check("ferr_set", frame_err, 1'b1);
    check("ferr_valid", ifc.rx_valid, 1'b0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    @(negedge clk);
    check("ferr_cleared", frame_err, 1'b0);

    // Back-to-back 0x11, 0x22 without consumer: overrun.
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    repeat (5) @(negedge clk);
    check("ovr_data", ifc.rx_data, 8'h22);
    check("ovr_valid", ifc.rx_valid, 1'b1);
    check("ovr_flag", overrun_err, 1'b1);
    check("ovr_frame_err", frame_err, 1'b0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    ifc.rx_ready = 1'b1;
    @(negedge clk);
    ifc.rx_ready = 1'b0;
    @(negedge clk);
    check("ovr_cleared", overrun_err, 1'b0);
    check("ovr_consumed", ifc.rx_valid, 1'b0);

    // Streaming with consumer always ready.
    got.delete();
    ifc.rx_ready = 1'b1;
    send_frame(8'h55, 1'b1);
    send_frame(8'hAA, 1'b1);
    send_frame(8'hFF, 1'b1);
    repeat (5) @(negedge clk);
    check("stream_count", got.size(), 3);
    check("stream_byte0", got.size() > 0 ? got[0] : 8'hxx, 8'h55);
    check("stream_byte1", got.size() > 1 ? got[1] : 8'hxx, 8'hAA);
    check("stream_byte2", got.size() > 2 ? got[2] : 8'hxx, 8'hFF);
    check("stream_valid_low", ifc.rx_valid, 1'b0);
    check("stream_no_overrun", overrun_err, 1'b0);

    // Reset during the last data bit of 0x81, then a clean 0x7E.
    got.delete();
    b81 = 8'h81;
    rx = 1'b0;
    bit_wait();
    for (int i = 0; i < 7; i++) begin
      rx = b81[i];
      bit_wait();
    end
    rx = b81[7];
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_valid", ifc.rx_valid, 1'b0);
    rst_n = 1'b1;
    repeat (CPB - 13) @(negedge clk);
`ifdef UART_RX_PARITY_EN
    rx = ^b81;
    bit_wait();
`endif
    rx = 1'b1;
    bit_wait();
    repeat (20) @(negedge clk);
    send_frame(8'h7E, 1'b1);
    repeat (5) @(negedge clk);
    check("midrst_count", got.size(), 1);
    check("midrst_byte", got.size() > 0 ? got[0] : 8'hxx, 8'h7E);
    check("midrst_frame_err", frame_err, 1'b0);

`ifdef UART_RX_PARITY_EN
    // 0x07 with parity bit 0 (even parity requires 1).
    ifc.rx_ready = 1'b0;
    got.delete();
    b81 = 8'h07;
    rx = 1'b0;
    bit_wait();
    for (int i = 0; i < 8; i++) begin
      rx = b81[i];
      bit_wait();
    end
    rx = 1'b0;
    bit_wait();
    rx = 1'b1;
    bit_wait();
    repeat (5) @(negedge clk);
    check("par_err_set", parity_err, 1'b1);
    check("par_no_valid", ifc.rx_valid, 1'b0);
    check("par_no_delivery", got.size(), 0);
`else
    check("parity_tied_low", parity_err, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
